// File: rtl/approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_pipe
// Brief    : Two-stage approximate adder (OR-ed low bits, AND carry) with
//            error reporting and saturating error statistics.
// Revision : 1.0
// ============================================================================
module approx_add_pipe #(
  parameter int WIDTH = 8,
  parameter int KMAX  = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [$clog2(KMAX+1)-1:0] k_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH:0]            sum,
  output logic [WIDTH:0]            err,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          op_count,
  output logic [CNT_W-1:0]          err_acc,
  output logic [WIDTH:0]            err_max,
  output logic                      stat_sat
);

  localparam int KW = $clog2(KMAX+1);
  localparam logic [CNT_W:0] CNT_ALL_ONES = {1'b0, {CNT_W{1'b1}}};

  logic                 rdy_en_q;
  logic                 s1_valid_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [KW-1:0]        k_q;
  logic                 s2_valid_q;
  logic [WIDTH:0]       sum_q;
  logic [WIDTH:0]       err_q;
  logic [CNT_W-1:0]     op_count_q;
  logic [CNT_W-1:0]     err_acc_q;
  logic [WIDTH:0]       err_max_q;
  logic                 stat_sat_q;

  logic                 adv1;
  logic                 adv2;
  logic                 accept;
  logic                 out_hs;
  logic [KW-1:0]        k_eff;

  logic [WIDTH:0]       kbit;
  logic [WIDTH:0]       low_mask;
  logic [WIDTH-1:0]     both;
  logic                 cin;
  logic [WIDTH:0]       hi;
  logic [WIDTH:0]       exact;
  logic [WIDTH:0]       sum_d;
  logic [WIDTH:0]       err_d;

  logic [CNT_W:0]       cnt_inc;
  logic [CNT_W:0]       acc_inc;
  logic [CNT_W-1:0]     op_count_d;
  logic [CNT_W-1:0]     err_acc_d;
  logic [WIDTH:0]       err_max_d;
  logic                 stat_sat_d;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  // rdy_en_q keeps in_ready low through reset and the cycle it is released in
  assign in_ready = rdy_en_q && adv1;
  assign accept   = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;
  assign k_eff    = (k_sel > KW'(KMAX)) ? KW'(KMAX) : k_sel;

  always_comb begin
    kbit     = (WIDTH+1)'(1) << k_q;
    low_mask = kbit - (WIDTH+1)'(1);
    both     = a_q & b_q;
    // kbit[WIDTH:1] selects bit k-1, and is empty for k=0 (exact mode)
    cin      = |(both & kbit[WIDTH:1]);
    hi       = ({1'b0, a_q} >> k_q) + ({1'b0, b_q} >> k_q) + (WIDTH+1)'(cin);
    sum_d    = (hi << k_q) | ({1'b0, a_q | b_q} & low_mask);
    exact    = {1'b0, a_q} + {1'b0, b_q};
    err_d    = (sum_d > exact) ? (sum_d - exact) : (exact - sum_d);
  end

  always_comb begin
    cnt_inc    = {1'b0, op_count_q} + (CNT_W+1)'(1);
    acc_inc    = {1'b0, err_acc_q} + (CNT_W+1)'(err_q);
    op_count_d = op_count_q;
    err_acc_d  = err_acc_q;
    err_max_d  = err_max_q;
    stat_sat_d = stat_sat_q;
    if (stat_clr) begin
      op_count_d = '0;
      err_acc_d  = '0;
      err_max_d  = '0;
      stat_sat_d = 1'b0;
    end else if (out_hs) begin
      op_count_d = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
      err_acc_d  = acc_inc[CNT_W] ? {CNT_W{1'b1}} : acc_inc[CNT_W-1:0];
      err_max_d  = (err_q > err_max_q) ? err_q : err_max_q;
      stat_sat_d = stat_sat_q || (cnt_inc >= CNT_ALL_ONES) || (acc_inc >= CNT_ALL_ONES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      err_q      <= '0;
      op_count_q <= '0;
      err_acc_q  <= '0;
      err_max_q  <= '0;
      stat_sat_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          a_q <= a;
          b_q <= b;
          k_q <= k_eff;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q <= sum_d;
          err_q <= err_d;
        end
      end
      op_count_q <= op_count_d;
      err_acc_q  <= err_acc_d;
      err_max_q  <= err_max_d;
      stat_sat_q <= stat_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign err       = err_q;
  assign op_count  = op_count_q;
  assign err_acc   = err_acc_q;
  assign err_max   = err_max_q;
  assign stat_sat  = stat_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_add_pipe
// Brief    : Directed, table-driven bench for approx_add_pipe (8/4/16).
// Revision : 1.0
// ============================================================================
module tb_approx_add_pipe;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] k;
    logic [8:0] sum;
    logic [8:0] err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  k_sel;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  sum;
  logic [8:0]  err;
  logic        stat_clr;
  logic [15:0] op_count;
  logic [15:0] err_acc;
  logic [8:0]  err_max;
  logic        stat_sat;

  int n_vec = 0;
  int n_bad = 0;
  int m_cnt = 0;
  int m_acc = 0;
  int m_max = 0;
  int m_sat = 0;

  vec_t vt [10];

  approx_add_pipe #(.WIDTH(8), .KMAX(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k_sel(k_sel), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .err(err), .stat_clr(stat_clr), .op_count(op_count),
    .err_acc(err_acc), .err_max(err_max), .stat_sat(stat_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_hs(input int e);
    m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    m_acc = (m_acc + e > 65535) ? 65535 : m_acc + e;
    if (e > m_max) m_max = e;
    if (m_cnt >= 65535 || m_acc >= 65535) m_sat = 1;
  endtask

  task automatic model_clr();
    m_cnt = 0; m_acc = 0; m_max = 0; m_sat = 0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, " op_count"}, 32'(op_count), 32'(m_cnt));
    chk({tag, " err_acc"},  32'(err_acc),  32'(m_acc));
    chk({tag, " err_max"},  32'(err_max),  32'(m_max));
    chk({tag, " stat_sat"}, 32'(stat_sat), 32'(m_sat));
  endtask

  // One isolated item: accept, result two edges later, handshake on the third.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; k_sel = v.k; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " sum"}, 32'(sum), 32'(v.sum));
    chk({tag, " err"}, 32'(err), 32'(v.err));
    model_hs(int'(v.err));
    @(negedge clk);
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
    check_stats(tag);
  endtask

  task automatic clear_stats();
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    model_clr();
  endtask

  task automatic stream(input int n, input vec_t v);
    int sent = 0;
    int guard = 0;
    @(negedge clk);
    a = v.a; b = v.b; k_sel = v.k; in_valid = 1'b1;
    #1;
    while (sent < n && guard < n + 100) begin
      if (in_ready) sent++;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (sent < n) chk("stream timeout", 32'(sent), 32'(n));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vt[0] = '{8'd200, 8'd100, 3'd0, 9'd300, 9'd0};
    vt[1] = '{8'd4,   8'd4,   3'd3, 9'd12,  9'd4};
    vt[2] = '{8'h0F,  8'h01,  3'd7, 9'd15,  9'd1};
    vt[3] = '{8'd8,   8'd8,   3'd4, 9'd24,  9'd8};
    vt[4] = '{8'd255, 8'd255, 3'd0, 9'd510, 9'd0};
    vt[5] = '{8'd1,   8'd1,   3'd1, 9'd3,   9'd1};
    vt[6] = '{8'h03,  8'h01,  3'd2, 9'd3,   9'd1};
    vt[7] = '{8'd255, 8'd255, 3'd4, 9'd511, 9'd1};
    vt[8] = '{8'hF0,  8'h10,  3'd5, 9'd256, 9'd0};
    vt[9] = '{8'h05,  8'h0A,  3'd2, 9'd15,  9'd0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; k_sel = '0;
    out_ready = 1'b1; stat_clr = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    check_stats("rst");
    @(negedge clk);
    @(negedge clk);
    chk("rst held in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Backpressure: three back-to-back offers with the consumer stalled.
    clear_stats();
    @(negedge clk);
    out_ready = 1'b0; a = 8'd1; b = 8'd2; k_sel = 3'd0; in_valid = 1'b1;
    #1 chk("bp in_ready0", 32'(in_ready), 32'd1);
    @(negedge clk);
    a = 8'd10; b = 8'd20;
    #1 chk("bp in_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    a = 8'd4; b = 8'd4; k_sel = 3'd3;
    #1 chk("bp in_ready2", 32'(in_ready), 32'd0);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp sum0", 32'(sum), 32'd3);
    repeat (2) @(negedge clk);
    chk("bp frozen in_ready", 32'(in_ready), 32'd0);
    chk("bp frozen sum", 32'(sum), 32'd3);
    chk("bp frozen err", 32'(err), 32'd0);
    chk("bp no count", 32'(op_count), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp sum1", 32'(sum), 32'd30);
    @(negedge clk);
    chk("bp sum2", 32'(sum), 32'd12);
    chk("bp err2", 32'(err), 32'd4);
    @(negedge clk);
    chk("bp drained", 32'(out_valid), 32'd0);
    chk("bp op_count", 32'(op_count), 32'd3);
    chk("bp err_acc", 32'(err_acc), 32'd4);

    // Saturation: 8191 items of err 8 stop just short, the next saturates.
    clear_stats();
    stream(8191, vt[3]);
    m_cnt = 8191; m_acc = 65528; m_max = 8; m_sat = 0;
    check_stats("presat");
    run_vec(vt[3], "sat1");
    run_vec(vt[3], "sat2");

    // Clear in the same cycle as an output handshake.
    @(negedge clk);
    a = vt[0].a; b = vt[0].b; k_sel = vt[0].k; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr out_valid", 32'(out_valid), 32'd1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    model_clr();
    chk("clr drained", 32'(out_valid), 32'd0);
    check_stats("clr");

    // Reset with two items in flight.
    @(negedge clk);
    out_ready = 1'b0; a = vt[0].a; b = vt[0].b; k_sel = vt[0].k; in_valid = 1'b1;
    @(negedge clk);
    a = vt[1].a; b = vt[1].b; k_sel = vt[1].k;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst sum", 32'(sum), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("mid post-rst in_ready", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("mid stale items", 32'(seen), 32'd0);
    end
    model_clr();
    run_vec(vt[1], "after-rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, legal 4..32.
REQ-002 SHALL have parameter KMAX, default 4: maximum number of approximated LSBs, legal 1..WIDTH-1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-007 SHALL have port in_ready, output, 1 bit: operand pair accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: unsigned operands.
REQ-009 SHALL have port k_sel, input, clog2(KMAX+1) bits: approximation level, sampled with the operands.
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH+1 bits: approximate sum.
REQ-013 SHALL have port err, output, WIDTH+1 bits: |exact sum - approximate sum| for the same item.
REQ-014 SHALL have port stat_clr, input, 1 bit: synchronous clear of the statistics.
REQ-015 SHALL have ports op_count, err_acc and err_max, output, CNT_W, CNT_W and WIDTH+1 bits respectively: number of completed results, accumulated err, largest err.
REQ-016 SHALL have port stat_sat, output, 1 bit: sticky flag, set when either counter saturates.

Function
REQ-017 SHALL compute with effective level k = min(k_sel, KMAX); k=0 gives the exact sum.
REQ-018 SHALL form sum bits i<k as a[i] OR b[i].
REQ-019 SHALL form the carry into bit k as a[k-1] AND b[k-1].
REQ-020 SHALL add bits k..WIDTH-1 exactly, including that carry, with sum[WIDTH] as the final carry-out.
REQ-021 SHALL compute err as an absolute value; the approximate sum may exceed the exact sum.
REQ-022 SHALL be a two-stage pipeline. Stage 1 registers a, b and k. Stage 2 registers sum and err.
REQ-023 SHALL give a latency of 2 cycles from accept to out_valid with out_ready held high, at a throughput of 1 item per cycle.
REQ-024 SHALL advance stage 2 when it is empty or out_ready is high.
REQ-025 SHALL advance stage 1 when it is empty or stage 2 advances.
REQ-026 SHALL drive in_ready from stage 1's advance condition combinationally; no combinational path from in_valid to in_ready.
REQ-027 SHALL hold sum and err stable while out_valid is high and out_ready is low.
REQ-028 SHALL never drop, duplicate or reorder items.
REQ-029 SHALL update the statistics on each output handshake (out_valid and out_ready high): op_count += 1, err_acc += err, err_max = max(err_max, err).
REQ-030 SHALL saturate op_count and err_acc at all-ones and set stat_sat when either does.
REQ-031 SHALL give stat_clr priority: zero op_count, err_acc, err_max and stat_sat; a handshake in the same cycle is not counted.
REQ-032 SHALL leave the datapath unaffected by stat_clr.
REQ-033 SHALL treat k_sel values above KMAX as KMAX; this is not an error.

Reset
REQ-034 SHALL, on rst_n low, immediately clear both stage valid flags and force all of the following to 0: out_valid, sum, err, op_count, err_acc, err_max, stat_sat.
REQ-035 SHALL hold in_ready low while rst_n is low and drive it high on the first clock after release.
REQ-036 SHALL discard in-flight items when reset is asserted mid-operation; they never appear at the output after reset.

Verification (WIDTH=8, KMAX=4, CNT_W=16)
REQ-037 SHALL cover exact mode: k_sel=0, a=200, b=100, out_ready=1 -> 2 cycles later sum=300, err=0, op_count=1.
REQ-038 SHALL cover an approximate result above exact: k_sel=3, a=4, b=4 -> sum=12, err=4, err_max=4, err_acc=4.
REQ-039 SHALL cover an approximate result below exact plus clamping: k_sel=7, a=0x0F, b=0x01 -> treated as k=4, sum=15, err=1.
REQ-040 SHALL cover backpressure: out_ready=0 while 3 items are offered back-to-back -> 2 accepted, then in_ready=0, outputs frozen; release -> the 3 items emerge in order, op_count=3.
REQ-041 SHALL cover statistics saturation and clear: preload err_acc near 0xFFFF by repeated k=4, a=b=8 items (err=8 each) -> err_acc saturates at 0xFFFF, stat_sat=1; stat_clr together with a handshake -> all statistics 0.
REQ-042 SHALL cover reset mid-flight: 2 items in the pipe, rst_n pulsed low -> out_valid=0 at once, and no stale item after release.
